chan_mux_reg: RTL and testbench
===============================

// Module: chan_mux_reg
// PURPOSE
//   Parametrised N-channel, W-bit registered multiplexer with a valid/ready output stage.
//   Generalises the 4:1 single-bit mux: one registered output, plus an auto-scan mode that steps through channels.
//   Sits between lab datapaths (switches, counters, ALU outputs) and a single display or serial consumer.
// PARAMETERS
//   WIDTH  1  data bits per channel
//   NCH    4  channel count, >=2; not required to be a power of two
//   SELW   2  select width, must equal clog2(NCH); checked at elaboration
// PORTS
//   clk        in   1           rising-edge clock
//   rst_n      in   1           asynchronous active-low reset
//   in_data    in   NCH*WIDTH   channel k occupies bits [k*WIDTH +: WIDTH]
//   sel        in   SELW        manual channel select
//   mode       in   1           0 = manual (use sel), 1 = scan (use internal pointer)
//   in_valid   in   1           request to capture a sample
//   out_ready  in   1           consumer accepts out_data
//   out_data   out  WIDTH       registered selected data
//   out_chan   out  SELW        channel index that out_data came from
//   out_valid  out  1           out_data holds an unconsumed sample
//   scan_wrap  out  1           1-cycle pulse: capture used channel NCH-1 in scan mode
//   sel_err    out  1           1-cycle pulse: manual capture with sel >= NCH
// BEHAVIOUR
//   Reset (async, rst_n=0): out_data=0, out_chan=0, out_valid=0, scan_wrap=0, sel_err=0, scan_ptr=0, mode_q=0.
//   FSM has 2 states, encoded by out_valid: EMPTY (0) and FULL (1).
//   accept = in_valid && (!out_valid || out_ready). Consumption and capture can happen in the same cycle.
//   EMPTY->FULL on accept. FULL->EMPTY on out_ready && !in_valid. FULL->FULL on accept, or while !out_ready.
//   Latency: sample registered on the accept edge; out_valid high the next cycle. No combinational in->out path.
//   ch = mode ? scan_ptr : sel. On accept: out_data=in_data[ch], out_chan=ch.
//   Manual mode, sel >= NCH: out_data=0, out_chan=sel, sel_err=1 for one cycle; sample is still delivered.
//   Scan: scan_ptr advances only on accept in scan mode; NCH-1 wraps to 0 with scan_wrap=1 in the same cycle as out_valid.
//   Mode change: mode_q is registered. When mode_q=0 and mode=1, scan_ptr loads 0 before the select, so the first scan capture is ch 0.
//   FULL && !out_ready: out_data and out_chan hold stable; inputs are ignored; scan_ptr does not move.
//   Reset mid-transfer drops the pending sample; no residual pulses are produced.
//   Pulses (scan_wrap, sel_err) are 0 on every cycle without a qualifying accept.
// CONFIGURATION
//   CHAN_MUX_PARITY_EN defined: adds output out_par (1 bit) = even parity (^) of out_data.
//     It is registered with out_data and resets to 0.
//   CHAN_MUX_PARITY_EN undefined: out_par port and logic are absent. All other behaviour is identical.
// STRUCTURE
//   Shared header chan_mux_defs.vh:
//     MODE_MANUAL=1'b0, MODE_SCAN=1'b1
//     ST_EMPTY/ST_FULL encodings
//     clog2 constant function, shared with the other lab blocks
//   Sub-module chan_scan_ctr (NCH, SELW):
//     ports clk, rst_n, clr, inc
//     outputs ptr, wrap
//     mod-NCH up-counter; clr has priority over inc
//   Top level instantiates chan_scan_ctr and contains the select mux, output register and FSM.
// TESTING (WIDTH=4, NCH=4 unless noted)
//   1 Reset: rst_n=0 mid-FULL -> all outputs 0 immediately, without waiting for clk.
//   2 Manual: in_data=16'hD2B7, sel=2, in_valid pulse, out_ready=1 -> next cycle out_data=4'h2, out_chan=2, out_valid=1.
//   3 Backpressure: out_ready=0, keep in_valid=1 while changing sel -> out_data/out_chan frozen.
//     Then out_ready=1 for 1 cycle with in_valid=1 -> new sample loaded with no bubble.
//   4 Scan: mode=1, in_valid=1, out_ready=1 for 6 cycles -> out_chan 0,1,2,3,0,1; scan_wrap high only with chan 3.
//   5 NCH=5, SELW=3 manual: sel=7 -> out_data=0, out_chan=7, sel_err=1 for one cycle.
//     Scan covers channels 0..4 and then wraps.
//   6 CHAN_MUX_PARITY_EN: out_data=4'b1011 -> out_par=1. Rebuild without the macro -> same results for tests 1-5.

Source files
------------

// File: rtl/chan_mux_reg_pkg.sv
// Shared definitions for the channel mux lab block: mode codes, FSM state
// encoding and an elaboration-time clog2 shared with the other lab blocks.
package chan_mux_reg_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Output stage state; the encoding doubles as out_valid.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/chan_mux_reg_scan_ctr.sv
// Mod-NCH scan pointer. ptr is the pointer in effect this cycle (clr already
// applied); wrap flags an inc that steps from NCH-1 back to 0.
module chan_scan_ctr #(
  parameter int NCH  = 4,
  parameter int SELW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            inc,
  output logic [SELW-1:0] ptr,
  output logic            wrap
);

  localparam logic [SELW-1:0] LAST = SELW'(NCH - 1);

  logic [SELW-1:0] cnt_q;

  // clr wins over the stored count; a coincident inc counts the capture that
  // was just taken from the restarted pointer, so the next one is ch 1.
  assign ptr  = clr ? '0 : cnt_q;
  assign wrap = inc && (ptr == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= wrap ? '0 : ptr + 1'b1;
    end else if (clr) begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/chan_mux_reg.sv
// NCH-channel, WIDTH-bit registered mux with a valid/ready output stage and
// an auto-scan mode. Define CHAN_MUX_PARITY_EN to add the out_par output.
module chan_mux_reg
  import chan_mux_reg_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  input  logic                 in_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  output logic                 scan_wrap,
`ifdef CHAN_MUX_PARITY_EN
  output logic                 out_par,
`endif
  output logic                 sel_err
);

  generate
    if (NCH < 2 || SELW != clog2(NCH)) begin : g_cfg_err
      $error("chan_mux_reg: need NCH >= 2 and SELW == clog2(NCH)");
    end
  endgenerate

  state_e          state;
  logic            mode_q;
  logic            accept;
  logic            scan_clr;
  logic            scan_inc;
  logic            scan_wrap_c;
  logic            bad_sel;
  logic [SELW-1:0] scan_ptr;
  logic [SELW-1:0] ch;
  logic [WIDTH-1:0] ch_data;
  logic [WIDTH-1:0] lane [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    assign lane[g] = in_data[g*WIDTH +: WIDTH];
  end

  assign accept   = in_valid && (state == ST_EMPTY || out_ready);
  assign scan_clr = (mode == MODE_SCAN) && (mode_q == MODE_MANUAL);
  assign scan_inc = accept && (mode == MODE_SCAN);
  assign ch       = (mode == MODE_SCAN) ? scan_ptr : sel;
  assign bad_sel  = (mode == MODE_MANUAL) && (int'(sel) >= NCH);

  chan_scan_ctr #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_scan (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (scan_clr),
    .inc   (scan_inc),
    .ptr   (scan_ptr),
    .wrap  (scan_wrap_c)
  );

  // Out-of-range selects match no lane and so deliver zero.
  always_comb begin
    ch_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (int'(ch) == k) ch_data = lane[k];
    end
  end

  assign out_valid = (state == ST_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      mode_q    <= MODE_MANUAL;
      out_data  <= '0;
      out_chan  <= '0;
      scan_wrap <= 1'b0;
      sel_err   <= 1'b0;
`ifdef CHAN_MUX_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else begin
      mode_q    <= mode;
      scan_wrap <= scan_wrap_c;
      sel_err   <= accept && bad_sel;
      if (accept) begin
        state    <= ST_FULL;
        out_data <= ch_data;
        out_chan <= ch;
`ifdef CHAN_MUX_PARITY_EN
        out_par  <= ^ch_data;
`endif
      end else if (state == ST_FULL && out_ready) begin
        state <= ST_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_chan_mux_reg.sv
// Directed bench for chan_mux_reg: a 4-channel table run plus hand sequences
// for async reset and a 5-channel instance (out-of-range select, scan wrap).
module tb_chan_mux_reg;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [15:0] in_data;
  logic [1:0]  sel;
  logic        mode, in_valid, out_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid, scan_wrap, sel_err;

  logic [19:0] in_data5;
  logic [2:0]  sel5;
  logic        mode5, in_valid5, out_ready5;
  logic [3:0]  out_data5;
  logic [2:0]  out_chan5;
  logic        out_valid5, scan_wrap5, sel_err5;

`ifdef CHAN_MUX_PARITY_EN
  logic        out_par, out_par5;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  chan_mux_reg #(.WIDTH(4), .NCH(4), .SELW(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .mode(mode),
    .in_valid(in_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .scan_wrap(scan_wrap),
`ifdef CHAN_MUX_PARITY_EN
    .out_par(out_par),
`endif
    .sel_err(sel_err)
  );

  chan_mux_reg #(.WIDTH(4), .NCH(5), .SELW(3)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data5), .sel(sel5), .mode(mode5),
    .in_valid(in_valid5), .out_ready(out_ready5), .out_data(out_data5),
    .out_chan(out_chan5), .out_valid(out_valid5), .scan_wrap(scan_wrap5),
`ifdef CHAN_MUX_PARITY_EN
    .out_par(out_par5),
`endif
    .sel_err(sel_err5)
  );

  typedef struct {
    logic [15:0] din;
    logic [1:0]  sel;
    logic        mode;
    logic        iv;
    logic        rdy;
    logic [3:0]  d;
    logic [1:0]  ch;
    logic        v;
    logic        wrap;
  } vec_t;

  vec_t tv [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    in_data = '0; sel = '0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data5 = '0; sel5 = '0; mode5 = 1'b0; in_valid5 = 1'b0; out_ready5 = 1'b0;

    // in_data D2B7: ch0=7 ch1=B ch2=2 ch3=D;  A5C3: ch0=3 ch1=C ch2=5 ch3=A
    //            din      sel   mode  iv    rdy   d      ch    v     wrap
    tv[0]  = '{16'hD2B7, 2'd2, 1'b0, 1'b1, 1'b1, 4'h2, 2'd2, 1'b1, 1'b0};
    tv[1]  = '{16'hD2B7, 2'd0, 1'b0, 1'b0, 1'b0, 4'h2, 2'd2, 1'b1, 1'b0};
    tv[2]  = '{16'hD2B7, 2'd1, 1'b0, 1'b1, 1'b0, 4'h2, 2'd2, 1'b1, 1'b0};
    tv[3]  = '{16'hD2B7, 2'd3, 1'b0, 1'b1, 1'b0, 4'h2, 2'd2, 1'b1, 1'b0};
    tv[4]  = '{16'hD2B7, 2'd3, 1'b0, 1'b1, 1'b1, 4'hD, 2'd3, 1'b1, 1'b0};
    tv[5]  = '{16'hD2B7, 2'd3, 1'b0, 1'b0, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0};
    tv[6]  = '{16'hD2B7, 2'd1, 1'b0, 1'b1, 1'b0, 4'hB, 2'd1, 1'b1, 1'b0};
    tv[7]  = '{16'hD2B7, 2'd1, 1'b0, 1'b0, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0};
    tv[8]  = '{16'hD2B7, 2'd3, 1'b1, 1'b1, 1'b1, 4'h7, 2'd0, 1'b1, 1'b0};
    tv[9]  = '{16'hD2B7, 2'd3, 1'b1, 1'b1, 1'b1, 4'hB, 2'd1, 1'b1, 1'b0};
    tv[10] = '{16'hD2B7, 2'd3, 1'b1, 1'b1, 1'b1, 4'h2, 2'd2, 1'b1, 1'b0};
    tv[11] = '{16'hD2B7, 2'd3, 1'b1, 1'b1, 1'b1, 4'hD, 2'd3, 1'b1, 1'b1};
    tv[12] = '{16'hD2B7, 2'd3, 1'b1, 1'b1, 1'b1, 4'h7, 2'd0, 1'b1, 1'b0};
    tv[13] = '{16'hD2B7, 2'd3, 1'b1, 1'b1, 1'b1, 4'hB, 2'd1, 1'b1, 1'b0};
    tv[14] = '{16'hD2B7, 2'd3, 1'b1, 1'b1, 1'b0, 4'hB, 2'd1, 1'b1, 1'b0};
    tv[15] = '{16'hD2B7, 2'd3, 1'b1, 1'b0, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0};
    tv[16] = '{16'hD2B7, 2'd3, 1'b1, 1'b1, 1'b1, 4'h2, 2'd2, 1'b1, 1'b0};
    tv[17] = '{16'hD2B7, 2'd0, 1'b0, 1'b1, 1'b1, 4'h7, 2'd0, 1'b1, 1'b0};
    tv[18] = '{16'hD2B7, 2'd2, 1'b1, 1'b1, 1'b1, 4'h7, 2'd0, 1'b1, 1'b0};
    tv[19] = '{16'hA5C3, 2'd2, 1'b1, 1'b1, 1'b1, 4'hC, 2'd1, 1'b1, 1'b0};
    tv[20] = '{16'hA5C3, 2'd2, 1'b1, 1'b1, 1'b1, 4'h5, 2'd2, 1'b1, 1'b0};
    tv[21] = '{16'hA5C3, 2'd2, 1'b1, 1'b1, 1'b1, 4'hA, 2'd3, 1'b1, 1'b1};

    #3;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_data",  32'(out_data),  32'd0);
    chk("reset_chan",  32'(out_chan),  32'd0);
    chk("reset_pulses", 32'({scan_wrap, sel_err, out_valid5, sel_err5}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      in_data = tv[i].din; sel = tv[i].sel; mode = tv[i].mode;
      in_valid = tv[i].iv; out_ready = tv[i].rdy;
      tick();
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(tv[i].v));
      chk($sformatf("v%0d_wrap", i),  32'(scan_wrap), 32'(tv[i].wrap));
      chk($sformatf("v%0d_selerr", i), 32'(sel_err), 32'd0);
      if (tv[i].v) begin
        chk($sformatf("v%0d_data", i), 32'(out_data), 32'(tv[i].d));
        chk($sformatf("v%0d_chan", i), 32'(out_chan), 32'(tv[i].ch));
`ifdef CHAN_MUX_PARITY_EN
        chk($sformatf("v%0d_par", i), 32'(out_par), 32'(^tv[i].d));
`endif
      end
    end

    // Async reset while FULL with a wrap pulse showing: clears without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_data",  32'(out_data),  32'd0);
    chk("async_rst_chan",  32'(out_chan),  32'd0);
    chk("async_rst_wrap",  32'(scan_wrap), 32'd0);
    in_valid = 1'b0; mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_pulses", 32'({scan_wrap, sel_err}), 32'd0);

    // NCH=5: channel k carries k+1.
    in_data5 = 20'h54321; in_valid5 = 1'b1; out_ready5 = 1'b1; mode5 = 1'b0;
    sel5 = 3'd7; tick();
    chk("n5_sel7_valid", 32'(out_valid5), 32'd1);
    chk("n5_sel7_data",  32'(out_data5),  32'd0);
    chk("n5_sel7_chan",  32'(out_chan5),  32'd7);
    chk("n5_sel7_err",   32'(sel_err5),   32'd1);
    sel5 = 3'd4; tick();
    chk("n5_sel4_data",  32'(out_data5),  32'd5);
    chk("n5_sel4_chan",  32'(out_chan5),  32'd4);
    chk("n5_sel4_err",   32'(sel_err5),   32'd0);
    sel5 = 3'd5; tick();
    chk("n5_sel5_data",  32'(out_data5),  32'd0);
    chk("n5_sel5_err",   32'(sel_err5),   32'd1);
    in_valid5 = 1'b0; tick();
    chk("n5_drain_valid", 32'(out_valid5), 32'd0);
    chk("n5_drain_err",   32'(sel_err5),   32'd0);

    mode5 = 1'b1; in_valid5 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("n5_scan%0d_chan", k), 32'(out_chan5), 32'(k % 5));
      chk($sformatf("n5_scan%0d_data", k), 32'(out_data5), 32'((k % 5) + 1));
      chk($sformatf("n5_scan%0d_wrap", k), 32'(scan_wrap5), 32'(k == 4));
      chk($sformatf("n5_scan%0d_err", k),  32'(sel_err5),   32'd0);
    end
    in_valid5 = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
